fire_codec_arbiter: RTL and testbench
=====================================

FIRE_CODEC_ARBITER -- requirements
Module: fire_codec_arbiter

Interface
REQ-001 Parameter N, default 64, codec word width in bits.
REQ-002 Parameter TIMEOUT, default 8191, BUSY-cycle limit before abort (used only with FIRE_ARB_TIMEOUT_EN).
REQ-003 Port clk  in  1  single clock; all logic on rising edge.
REQ-004 Port rst  in  1  reset; synchronous, active-high.
REQ-005 Port req  in  2  per-requester request; bit i = requester i.
REQ-006 Port req_mode  in  2  per-requester operation; 0 = encode, 1 = decode.
REQ-007 Port req_data  in  2*N  per-requester word; requester i at bits [i*N +: N].
REQ-008 Port gnt  out  2  one-cycle grant pulse to the selected requester.
REQ-009 Port rsp_valid  out  2  one-cycle response pulse to the granted requester.
REQ-010 Port rsp_data  out  N  result word, valid while any rsp_valid bit is high.
REQ-011 Port rsp_err  out  1  abort flag, qualified by rsp_valid.
REQ-012 Port busy  out  1  high in every state except IDLE.
REQ-013 Port cdc_mode  out  3  codec command; 000 idle, 001 encode, 010 decode.
REQ-014 Port cdc_data  out  N  codec input word.
REQ-015 Port cdc_done  in  1  one-cycle codec completion pulse.
REQ-016 Port cdc_result  in  N  codec output word, valid with cdc_done.
REQ-017 Port cdc_rst  out  1  one-cycle codec abort reset.

Function
REQ-018 FSM states: IDLE, ISSUE, BUSY, RESP; ABORT present only with FIRE_ARB_TIMEOUT_EN.
REQ-019 IDLE: with req != 0, select requester s, latch its mode and data, pulse gnt[s], and go to ISSUE on the next edge; with req == 0, stay in IDLE.
REQ-020 Arbitration: round-robin on a 1-bit last pointer; when both request, the requester not equal to last wins; when one requests, it wins; last <= s on each grant.
REQ-021 ISSUE: drive cdc_mode = 001 (encode) or 010 (decode) for exactly one cycle, then go to BUSY.
REQ-022 In every state other than ISSUE, cdc_mode = 000, so the codec never re-samples a command when it returns to idle.
REQ-023 cdc_data holds the latched word from ISSUE through the end of BUSY, and is 0 otherwise.
REQ-024 BUSY: on cdc_done, latch cdc_result and go to RESP; a cdc_done seen in ISSUE or IDLE is ignored.
REQ-025 RESP: for one cycle, rsp_valid[s] = 1, rsp_data = latched result, rsp_err = 0; then go to IDLE.
REQ-026 Requester i holds req[i], req_mode and its data until gnt[i]; after the grant, req[i] is ignored until RESP completes.
REQ-027 A new request is granted no earlier than the cycle after RESP (single outstanding operation).
REQ-028 rsp_data is 0 whenever rsp_valid == 0.
REQ-029 gnt and rsp_valid are never both nonzero in the same cycle.

Reset
REQ-030 On rst high at a clock edge: state <= IDLE, last <= 1 (so requester 0 wins the first tie), and all latched mode, data and result registers cleared.
REQ-031 While in reset, every output is 0: gnt, rsp_valid, rsp_data, rsp_err, busy, cdc_mode, cdc_data, cdc_rst.
REQ-032 A reset asserted mid-operation discards the operation and produces no rsp_valid; the codec shares rst and is reset by the same edge.

Configuration
REQ-033 Macro FIRE_ARB_TIMEOUT_EN defined: a 13-bit counter clears on entry to BUSY and increments each BUSY cycle.
REQ-034 With the macro, when the counter reaches TIMEOUT without cdc_done, go to ABORT and pulse cdc_rst for one cycle.
REQ-035 With the macro, the cycle after ABORT the FSM goes to RESP with rsp_err = 1 and rsp_data = 0, then returns to IDLE.
REQ-036 With the macro, if cdc_done and the timeout occur in the same cycle, cdc_done wins and no abort occurs.
REQ-037 Macro FIRE_ARB_TIMEOUT_EN undefined: no counter and no ABORT state, cdc_rst is tied to 0, rsp_err is tied to 0, and BUSY waits indefinitely for cdc_done.

Verification
REQ-038 req=01, mode=0, data=64'h00000012_3456789A; codec model returns done after 45 cycles -> gnt=01, cdc_mode=001 for one cycle, then rsp_valid=01 carrying the model result and rsp_err=0.
REQ-039 req=11 held from reset -> first gnt=01, then gnt=10, then gnt=01, one RESP between each grant.
REQ-040 Requester 1 decode, data=64'hFFFF0000_FFFF0000, result 64'h1234 -> cdc_mode=010 for exactly one cycle, cdc_data stable for all BUSY cycles, and rsp_data=64'h1234.
REQ-041 rst asserted 10 cycles into BUSY -> all outputs 0 the next cycle, no rsp_valid, and req=01 afterwards is granted normally.
REQ-042 FIRE_ARB_TIMEOUT_EN with TIMEOUT=16 and codec silent -> cdc_rst pulses after 16 BUSY cycles, then rsp_valid with rsp_err=1 and rsp_data=0.
REQ-043 FIRE_ARB_TIMEOUT_EN with TIMEOUT=16 and cdc_done on the same cycle the counter reaches 16 -> normal response with rsp_err=0 and no cdc_rst pulse.

Source files
------------

// File: rtl/fire_codec_arbiter.sv
// rtl/fire_codec_arbiter.sv - two-requester round-robin arbiter in front of a single encode/decode codec
//
// Grants one of two requesters, issues a one-cycle encode/decode command to the codec,
// waits for completion and returns the result as a one-cycle response to the winner.
// Optional feature macro: FIRE_ARB_TIMEOUT_EN (BUSY watchdog, ABORT state, cdc_rst pulse).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req[1:0]                 per-requester request
//   req_mode[1:0]            per-requester operation (0 encode, 1 decode)
//   req_data[2*N-1:0]        per-requester word, requester i at [i*N +: N]
//   gnt[1:0]                 one-cycle grant pulse
//   rsp_valid[1:0]           one-cycle response pulse to the granted requester
//   rsp_data[N-1:0]          result word, zero when no response
//   rsp_err                  abort flag, qualified by rsp_valid
//   busy                     high outside IDLE
//   cdc_mode[2:0]            codec command (000 idle, 001 encode, 010 decode)
//   cdc_data[N-1:0]          codec input word
//   cdc_done, cdc_result     codec completion pulse and result
//   cdc_rst                  one-cycle codec abort reset
module fire_codec_arbiter #(
   parameter int N       = 64,
   parameter int TIMEOUT = 8191
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [1:0]     req,
   input  logic [1:0]     req_mode,
   input  logic [2*N-1:0] req_data,
   output logic [1:0]     gnt,
   output logic [1:0]     rsp_valid,
   output logic [N-1:0]   rsp_data,
   output logic           rsp_err,
   output logic           busy,
   output logic [2:0]     cdc_mode,
   output logic [N-1:0]   cdc_data,
   input  logic           cdc_done,
   input  logic [N-1:0]   cdc_result,
   output logic           cdc_rst
);

`ifdef FIRE_ARB_TIMEOUT_EN
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP, S_ABORT} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_t;
`endif

   state_t       r_state;
   state_t       w_next;
   logic         r_last;
   logic         r_sel;
   logic         r_mode;
   logic [N-1:0] r_data;
   logic [N-1:0] r_result;
   logic         w_sel;
   logic         w_grant;
`ifdef FIRE_ARB_TIMEOUT_EN
   logic         r_err;
   logic [12:0]  r_cnt;
`endif

   // On a tie the requester that did not win last time is chosen.
   assign w_sel = (req == 2'b11) ? ~r_last : req[1];

   always_comb begin
      w_next    = r_state;
      w_grant   = 1'b0;
      gnt       = 2'b00;
      rsp_valid = 2'b00;
      rsp_data  = '0;
      rsp_err   = 1'b0;
      busy      = 1'b0;
      cdc_mode  = 3'b000;
      cdc_data  = '0;
      cdc_rst   = 1'b0;
      // Outputs are forced low combinationally while rst is high, not only after the edge.
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (req != 2'b00) begin
                  w_grant    = 1'b1;
                  gnt[w_sel] = 1'b1;
                  w_next     = S_ISSUE;
               end
            end
            S_ISSUE: begin
               busy     = 1'b1;
               cdc_mode = r_mode ? 3'b010 : 3'b001;
               cdc_data = r_data;
               w_next   = S_BUSY;
            end
            S_BUSY: begin
               busy     = 1'b1;
               cdc_data = r_data;
               if (cdc_done) begin
                  w_next = S_RESP;
               end
`ifdef FIRE_ARB_TIMEOUT_EN
               // r_cnt counts BUSY cycles already completed; this is the TIMEOUT-th one.
               else if (r_cnt == 13'(TIMEOUT - 1)) begin
                  w_next = S_ABORT;
               end
`endif
            end
`ifdef FIRE_ARB_TIMEOUT_EN
            S_ABORT: begin
               busy    = 1'b1;
               cdc_rst = 1'b1;
               w_next  = S_RESP;
            end
`endif
            S_RESP: begin
               busy             = 1'b1;
               rsp_valid[r_sel] = 1'b1;
               rsp_data         = r_result;
`ifdef FIRE_ARB_TIMEOUT_EN
               rsp_err          = r_err;
`endif
               w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_last   <= 1'b1;
         r_sel    <= 1'b0;
         r_mode   <= 1'b0;
         r_data   <= '0;
         r_result <= '0;
`ifdef FIRE_ARB_TIMEOUT_EN
         r_err    <= 1'b0;
         r_cnt    <= '0;
`endif
      end else begin
         r_state <= w_next;
         if (w_grant) begin
            r_last   <= w_sel;
            r_sel    <= w_sel;
            r_mode   <= w_sel ? req_mode[1] : req_mode[0];
            r_data   <= w_sel ? req_data[2*N-1:N] : req_data[N-1:0];
            r_result <= '0;
`ifdef FIRE_ARB_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
         end
         if (r_state == S_BUSY && cdc_done) begin
            r_result <= cdc_result;
         end
`ifdef FIRE_ARB_TIMEOUT_EN
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt + 13'd1;
         end
         if (r_state == S_ABORT) begin
            r_result <= '0;
            r_err    <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fire_codec_arbiter.sv
// tb/tb_fire_codec_arbiter.sv - scoreboard bench for fire_codec_arbiter
module tb_fire_codec_arbiter;
   localparam int N = 64;

   logic           clk;
   logic           rst;
   logic [1:0]     req;
   logic [1:0]     req_mode;
   logic [2*N-1:0] req_data;
   logic [1:0]     gnt;
   logic [1:0]     rsp_valid;
   logic [N-1:0]   rsp_data;
   logic           rsp_err;
   logic           busy;
   logic [2:0]     cdc_mode;
   logic [N-1:0]   cdc_data;
   logic           cdc_done;
   logic [N-1:0]   cdc_result;
   logic           cdc_rst;

   fire_codec_arbiter #(.N(N), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .req(req), .req_mode(req_mode), .req_data(req_data),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .cdc_mode(cdc_mode), .cdc_data(cdc_data), .cdc_done(cdc_done),
      .cdc_result(cdc_result), .cdc_rst(cdc_rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   typedef struct {
      logic [1:0]  v;
      logic [63:0] d;
      logic        e;
   } exp_t;
   exp_t sb[$];

   // Codec model: answers `delay` cycles after the command, encode = ~data, decode = dec_result.
   logic [63:0] dec_result;
   int          delay;
   bit          silent;
   int          m_cnt;
   logic [63:0] m_res;

   always @(negedge clk) begin
      if (rst || cdc_rst) begin
         cdc_done   = 1'b0;
         cdc_result = '0;
         m_cnt      = 0;
      end else if (cdc_mode != 3'b000) begin
         m_cnt      = delay;
         m_res      = (cdc_mode == 3'b010) ? dec_result : ~cdc_data;
         cdc_done   = 1'b0;
         cdc_result = '0;
      end else if (m_cnt > 0) begin
         m_cnt--;
         if (m_cnt == 0 && !silent) begin
            cdc_done   = 1'b1;
            cdc_result = m_res;
         end
      end else begin
         cdc_done   = 1'b0;
         cdc_result = '0;
      end
   end

   // Monitor: invariants every cycle and scoreboard pop on each response.
   int          rsp_cnt     = 0;
   int          cdc_rst_cnt = 0;
   logic [63:0] exp_cdc_data;
   exp_t        e;

   always @(negedge clk) begin
      if (!rst) begin
         chk("gnt_rsp_exclusive", 64'((gnt != 2'b00) && (rsp_valid != 2'b00)), 64'd0);
         if (rsp_valid == 2'b00) chk("rsp_data_idle_zero", rsp_data, 64'd0);
         if (cdc_rst) cdc_rst_cnt++;
         if (busy && rsp_valid == 2'b00 && !cdc_rst) chk("cdc_data_stable", cdc_data, exp_cdc_data);
         if (rsp_valid != 2'b00) begin
            rsp_cnt++;
            if (sb.size() == 0) begin
               chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(e.v));
               chk("rsp_data", rsp_data, e.d);
               chk("rsp_err", 64'(rsp_err), 64'(e.e));
            end
         end
      end
   end

   task automatic wait_rsp(input string tag, input int bound, output int k);
      k = 0;
      while (rsp_valid == 2'b00 && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 64'(rsp_valid != 2'b00), 64'd1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_gnt"}, 64'(gnt), 64'd0);
      chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({pfx, "_rsp_data"}, rsp_data, 64'd0);
      chk({pfx, "_rsp_err"}, 64'(rsp_err), 64'd0);
      chk({pfx, "_busy"}, 64'(busy), 64'd0);
      chk({pfx, "_cdc_mode"}, 64'(cdc_mode), 64'd0);
      chk({pfx, "_cdc_data"}, cdc_data, 64'd0);
      chk({pfx, "_cdc_rst"}, 64'(cdc_rst), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "global timeout");
   end

   initial begin
      int          k;
      int          base;
      logic [1:0]  exp_g [3];
      logic [63:0] d0;
      logic [63:0] d1;

      exp_g = '{2'b01, 2'b10, 2'b01};
      rst = 1'b1; req = 2'b00; req_mode = 2'b00; req_data = '0;
      delay = 10; silent = 1'b0; dec_result = '0; exp_cdc_data = '0;

      // Reset: outputs low even with both requests asserted.
      @(negedge clk);
      req = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      req = 2'b00;
      rst = 1'b0;

      // Single encode from requester 0, 45-cycle codec.
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      d0 = 64'h00000012_3456789A;
      req = 2'b01; req_mode = 2'b00; req_data = {64'd0, d0}; delay = 45;
      #1;
      chk("enc_gnt", 64'(gnt), 64'd1);
      exp_cdc_data = d0;
      sb.push_back('{2'b01, ~d0, 1'b0});
      @(negedge clk);
      req = 2'b00;
      chk("enc_cdc_mode_issue", 64'(cdc_mode), 64'd1);
      chk("enc_busy", 64'(busy), 64'd1);
      @(negedge clk);
      chk("enc_cdc_mode_after", 64'(cdc_mode), 64'd0);
      wait_rsp("enc_rsp_seen", 200, k);
      chk("enc_latency", 64'(k), 64'd45);
      @(negedge clk);
      chk("enc_back_idle", 64'(busy), 64'd0);

      // Both requesting from reset: alternate 01,10,01 with one response between grants.
      rst = 1'b1;
      d0 = 64'h1111_2222_3333_4444;
      d1 = 64'h5555_6666_7777_8888;
      req = 2'b11; req_mode = 2'b10; req_data = {d1, d0};
      dec_result = 64'h0000_0000_00DE_C0DE; delay = 5;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      base = rsp_cnt;
      for (int g = 0; g < 3; g++) begin
         k = 0;
         #1;
         while (gnt == 2'b00 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
         end
         chk($sformatf("rr_gnt%0d", g), 64'(gnt), 64'(exp_g[g]));
         chk($sformatf("rr_rsp_between%0d", g), 64'(rsp_cnt - base), 64'(g));
         exp_cdc_data = exp_g[g][1] ? d1 : d0;
         sb.push_back('{exp_g[g], exp_g[g][1] ? dec_result : ~d0, 1'b0});
         @(negedge clk);
      end
      req = 2'b00;
      wait_rsp("rr_last_rsp", 100, k);
      @(negedge clk);

      // Requester 1 decode.
      d1 = 64'hFFFF0000_FFFF0000;
      req = 2'b10; req_mode = 2'b10; req_data = {d1, 64'd0};
      dec_result = 64'h1234; delay = 20;
      #1;
      chk("dec_gnt", 64'(gnt), 64'd2);
      exp_cdc_data = d1;
      sb.push_back('{2'b10, 64'h1234, 1'b0});
      @(negedge clk);
      req = 2'b00;
      chk("dec_cdc_mode_issue", 64'(cdc_mode), 64'd2);
      @(negedge clk);
      chk("dec_cdc_mode_after", 64'(cdc_mode), 64'd0);
      wait_rsp("dec_rsp_seen", 100, k);
      chk("dec_latency", 64'(k), 64'd20);
      @(negedge clk);

      // Reset 10 cycles into BUSY discards the operation.
      d0 = 64'hCAFE_F00D_0BAD_BEEF;
      req = 2'b01; req_mode = 2'b00; req_data = {64'd0, d0}; delay = 100;
      #1;
      chk("mid_gnt", 64'(gnt), 64'd1);
      exp_cdc_data = d0;
      @(negedge clk);
      req = 2'b00;
      repeat (10) @(negedge clk);
      chk("mid_busy_before", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("mid_rst");
      rst = 1'b0;
      base = rsp_cnt;
      repeat (120) @(negedge clk);
      chk("mid_no_rsp", 64'(rsp_cnt - base), 64'd0);
      chk("mid_idle", 64'(busy), 64'd0);
      d0 = 64'h0123_4567_89AB_CDEF;
      req = 2'b01; req_mode = 2'b00; req_data = {64'd0, d0}; delay = 3;
      #1;
      chk("post_rst_gnt", 64'(gnt), 64'd1);
      exp_cdc_data = d0;
      sb.push_back('{2'b01, ~d0, 1'b0});
      @(negedge clk);
      req = 2'b00;
      wait_rsp("post_rst_rsp", 50, k);
      @(negedge clk);

`ifdef FIRE_ARB_TIMEOUT_EN
      // Silent codec: ABORT after 16 BUSY cycles, then error response.
      silent = 1'b1;
      d0 = 64'hAAAA_5555_AAAA_5555;
      req = 2'b01; req_mode = 2'b00; req_data = {64'd0, d0}; delay = 40;
      #1;
      chk("to_gnt", 64'(gnt), 64'd1);
      exp_cdc_data = d0;
      sb.push_back('{2'b01, 64'd0, 1'b1});
      @(negedge clk);
      req = 2'b00;
      k = 0;
      while (!cdc_rst && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("to_cdc_rst_seen", 64'(cdc_rst), 64'd1);
      chk("to_cdc_rst_cycle", 64'(k), 64'd17);
      @(negedge clk);
      chk("to_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("to_rsp_err", 64'(rsp_err), 64'd1);
      @(negedge clk);
      silent = 1'b0;

      // Done on the timeout cycle: normal response, no abort.
      base = cdc_rst_cnt;
      d0 = 64'h0F0F_0F0F_1234_5678;
      req = 2'b01; req_mode = 2'b00; req_data = {64'd0, d0}; delay = 16;
      #1;
      chk("race_gnt", 64'(gnt), 64'd1);
      exp_cdc_data = d0;
      sb.push_back('{2'b01, ~d0, 1'b0});
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      wait_rsp("race_rsp_seen", 100, k);
      chk("race_latency", 64'(k), 64'd16);
      chk("race_no_cdc_rst", 64'(cdc_rst_cnt - base), 64'd0);
      @(negedge clk);
`endif

      @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
